// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack bus master for MIPS loads/stores,
// with byte-enable/lane formation, load extraction, pipeline stall and timeout abort.
module mem_access_unit #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        valid_in,
   input  logic [31:0] aluResult,
   input  logic [31:0] writeData,
   input  logic [4:0]  muxInst,
   input  logic [1:0]  WB,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [1:0]  memSize,
   input  logic        memUnsigned,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic [31:0] readData,
   output logic [31:0] aluResultOut,
   output logic [4:0]  muxInstOut,
   output logic [1:0]  WBOut,
   output logic        stall,
   output logic        misaligned,
   output logic        bus_error
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

   state_t      state;
   logic [15:0] wait_cnt;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        is_byte, is_half, is_word;
   logic        memop, align_ok;
   logic [1:0]  a;
   logic [3:0]  be_n;
   logic [31:0] wdata_n, shifted, load_n;

   always_comb begin
      a        = aluResult[1:0];
      is_byte  = (memSize == 2'b00);
      is_half  = (memSize == 2'b01);
      is_word  = memSize[1];
      memop    = valid_in & (memRead | memWrite);
      align_ok = is_byte | (is_half & ~a[0]) | (is_word & (a == 2'b00));

      be_n    = 4'b1111;
      wdata_n = writeData;
      if (is_byte) begin
         be_n    = 4'b0001 << a;
         wdata_n = {4{writeData[7:0]}};
      end else if (is_half) begin
         be_n    = 4'b0011 << a;
         wdata_n = {2{writeData[15:0]}};
      end

      shifted = mem_rdata >> {a, 3'b000};
      load_n  = shifted;
      if (is_byte)
         load_n = memUnsigned ? {24'h000000, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      else if (is_half)
         load_n = memUnsigned ? {16'h0000, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (memop && align_ok) begin
                  state     <= BUSY;
                  mem_req   <= 1'b1;
                  mem_we    <= memWrite & ~memRead;
                  mem_addr  <= {aluResult[31:2], 2'b00};
                  mem_be    <= be_n;
                  mem_wdata <= wdata_n;
                  wait_cnt  <= '0;
               end
            end
            BUSY: begin
               // ack is checked first so it wins over a coincident timeout
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  rdata_q <= memRead ? load_n : '0;
                  err_q   <= 1'b0;
                  state   <= DONE;
               end else if (wait_cnt == WAIT_LAST) begin
                  mem_req <= 1'b0;
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state   <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            DONE: begin
               err_q <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Combinational outputs are gated so everything reads 0 during reset.
   always_comb begin
      stall        = reset_n & memop & align_ok & (state != DONE);
      misaligned   = reset_n & memop & ~align_ok;
      readData     = (reset_n && state == DONE) ? rdata_q : '0;
      bus_error    = reset_n & (state == DONE) & err_q;
      aluResultOut = reset_n ? aluResult : '0;
      muxInstOut   = reset_n ? muxInst : '0;
      if (!reset_n || !valid_in)
         WBOut = 2'b00;
      else if (state == DONE)
         WBOut = err_q ? 2'b00 : WB;
      else if (memop && !align_ok)
         WBOut = 2'b00;
      else
         WBOut = WB;
   end

endmodule
